// File: rtl/router_tile_scheduler_if.sv
// Beat bus between the tile scheduler and the router address generator.
// The scheduler drives position/pass information; the address generator answers with i_ready.
interface router_tile_scheduler_if #(
  parameter int SA_HEIGHT  = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int PASS_BITS  = 4
);
  localparam int ROW_W = $clog2(SA_HEIGHT);

  logic                  o_valid;
  logic                  i_ready;
  logic [ROW_W-1:0]      o_row_number;
  logic [ADDR_WIDTH-1:0] o_o_x;
  logic [ADDR_WIDTH-1:0] o_o_y;
  logic [ADDR_WIDTH-1:0] o_i_x;
  logic [ADDR_WIDTH-1:0] o_i_y;
  logic [PASS_BITS-1:0]  o_pass;
  logic                  o_tile_last;

  modport master (
    output o_valid, o_row_number, o_o_x, o_o_y, o_i_x, o_i_y, o_pass, o_tile_last,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_row_number, o_o_x, o_o_y, o_i_x, o_i_y, o_pass, o_tile_last,
    output i_ready
  );
endinterface

// File: rtl/router_tile_scheduler.sv
// Walks the output map (y inner, x outer) in tiles of up to SA_HEIGHT positions,
// waiting for the array between tiles and repeating the map once per weight pass.
module router_tile_scheduler #(
  parameter int SA_HEIGHT   = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int STRIDE_BITS = 2,
  parameter int PASS_BITS   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_reg_clear,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_o_width,
  input  logic [ADDR_WIDTH-1:0]         i_o_height,
  input  logic [STRIDE_BITS-1:0]        i_stride,
  input  logic [PASS_BITS-1:0]          i_pass_count,
  input  logic                          i_compute_done,
  router_tile_scheduler_if.master       beat,
  output logic [$clog2(SA_HEIGHT):0]    o_rows_used,
  output logic                          o_busy,
  output logic                          o_done
);
  localparam int ROW_W = $clog2(SA_HEIGHT);
  localparam int PROD_W = ADDR_WIDTH + STRIDE_BITS;
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = 1;
  localparam logic [PASS_BITS:0]    P_ONE    = 1;
  localparam logic [ROW_W-1:0]      R_ONE    = 1;
  localparam logic [ROW_W:0]        RU_ONE   = 1;
  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(SA_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   width_q, width_d, height_q, height_d;
  logic [ADDR_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [STRIDE_BITS-1:0]  stride_q, stride_d;
  logic [PASS_BITS-1:0]    pass_cnt_q, pass_cnt_d, pass_q, pass_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [ROW_W:0]          rows_used_q, rows_used_d;
  logic                    map_done_q, map_done_d;
  logic                    last_pos, tile_last;
  logic [PASS_BITS:0]      pass_inc;
  logic [PROD_W-1:0]       prod_x, prod_y;

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    stride_d    = stride_q;
    pass_cnt_d  = pass_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    pass_d      = pass_q;
    row_d       = row_q;
    rows_used_d = rows_used_q;
    map_done_d  = map_done_q;

    last_pos  = (x_q == width_q - A_ONE) && (y_q == height_q - A_ONE);
    tile_last = (state_q == S_DISPATCH) && ((row_q == ROW_LAST) || last_pos);
    pass_inc  = {1'b0, pass_q} + P_ONE;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          width_d     = i_o_width;
          height_d    = i_o_height;
          stride_d    = i_stride;
          pass_cnt_d  = i_pass_count;
          x_d         = '0;
          y_d         = '0;
          pass_d      = '0;
          row_d       = '0;
          rows_used_d = '0;
          map_done_d  = 1'b0;
          if ((i_o_width == '0) || (i_o_height == '0) || (i_pass_count == '0))
            state_d = S_DONE;
          else
            state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (beat.i_ready) begin
          rows_used_d = {1'b0, row_q} + RU_ONE;
          row_d       = tile_last ? '0 : row_q + R_ONE;
          // The final position is held rather than advanced so x never steps past the extent.
          if (last_pos) begin
            map_done_d = 1'b1;
          end else if (y_q == height_q - A_ONE) begin
            y_d = '0;
            x_d = x_q + A_ONE;
          end else begin
            y_d = y_q + A_ONE;
          end
          if (tile_last)
            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_compute_done) begin
          row_d = '0;
          if (!map_done_q) begin
            state_d = S_DISPATCH;
          end else if (pass_inc < {1'b0, pass_cnt_q}) begin
            pass_d     = pass_inc[PASS_BITS-1:0];
            x_d        = '0;
            y_d        = '0;
            map_done_d = 1'b0;
            state_d    = S_DISPATCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_reg_clear) begin
      state_d     = S_IDLE;
      width_d     = '0;
      height_d    = '0;
      stride_d    = '0;
      pass_cnt_d  = '0;
      x_d         = '0;
      y_d         = '0;
      pass_d      = '0;
      row_d       = '0;
      rows_used_d = '0;
      map_done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      stride_q    <= '0;
      pass_cnt_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pass_q      <= '0;
      row_q       <= '0;
      rows_used_q <= '0;
      map_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      stride_q    <= stride_d;
      pass_cnt_q  <= pass_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pass_q      <= pass_d;
      row_q       <= row_d;
      rows_used_q <= rows_used_d;
      map_done_q  <= map_done_d;
    end
  end

  // Input coordinates depend only on registered state, so no input-to-output paths exist.
  assign prod_x = {{STRIDE_BITS{1'b0}}, x_q} * {{ADDR_WIDTH{1'b0}}, stride_q};
  assign prod_y = {{STRIDE_BITS{1'b0}}, y_q} * {{ADDR_WIDTH{1'b0}}, stride_q};

  assign beat.o_valid      = (state_q == S_DISPATCH);
  assign beat.o_row_number = row_q;
  assign beat.o_o_x        = x_q;
  assign beat.o_o_y        = y_q;
  assign beat.o_i_x        = prod_x[ADDR_WIDTH-1:0];
  assign beat.o_i_y        = prod_y[ADDR_WIDTH-1:0];
  assign beat.o_pass       = pass_q;
  assign beat.o_tile_last  = tile_last;
  assign o_rows_used       = rows_used_q;
  assign o_busy            = (state_q == S_DISPATCH) || (state_q == S_WAIT);
  assign o_done            = (state_q == S_DONE);
endmodule
